alu_share_arbiter: RTL

- Shares the single combinational 16-bit `alu` between two requesters: port 0 (execute stage) and port 1 (branch/compare unit).
- Accepts one operation at a time over a valid/ready handshake and picks between the ports with round-robin priority.
- Latches the operands and drives them onto the shared ALU inputs for EXEC_CYCLES cycles, then registers `alu_res`.
- Returns the result to the granted port over a valid/ready response handshake.

---
 rtl/alu_share_arbiter_if.sv | 28 ++
 rtl/alu_share_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU share arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req0_OpCode, req1_OpCode;
    logic [1:0]  req0_funct,  req1_funct;
    logic [15:0] req0_Rs, req0_Rt, req1_Rs, req1_Rt;
    logic [15:0] req0_Pc, req1_Pc;
    logic [7:0]  req0_Imm, req1_Imm;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data;

    modport master (
        output req_valid, req0_OpCode, req1_OpCode, req0_funct, req1_funct,
               req0_Rs, req0_Rt, req1_Rs, req1_Rt, req0_Pc, req1_Pc,
               req0_Imm, req1_Imm, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req0_OpCode, req1_OpCode, req0_funct, req1_funct,
               req0_Rs, req0_Rt, req1_Rs, req1_Rt, req0_Pc, req1_Pc,
               req0_Imm, req1_Imm, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational 16-bit ALU between two requesters;
// one operation in flight, operands held for EXEC_CYCLES, result returned by handshake.
module alu_share_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus,
    output logic [4:0]           alu_OpCode,
    output logic [1:0]           alu_funct,
    output logic [15:0]          alu_Rs,
    output logic [15:0]          alu_Rt,
    output logic [15:0]          alu_Pc,
    output logic [7:0]           alu_Imm,
    input  logic [15:0]          alu_res,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_next;
    logic [2:0] cnt;
    logic       last_grant;
    logic       gnt;
    logic       chosen;
    logic       accept;

    // Contention goes to the port that was not served last.
    always_comb begin
        chosen = 1'b0;
        if (&bus.req_valid)
            chosen = ~last_grant;
        else if (bus.req_valid[1])
            chosen = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 2'b00;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid[chosen]) begin
                    bus.req_ready[chosen] = 1'b1;
                    accept                = 1'b1;
                    state_next            = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 3'd0)
                    state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[gnt])
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // alu_* registers keep their last operands after returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 3'd0;
            last_grant    <= 1'b1;
            gnt           <= 1'b0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_data  <= 16'h0000;
            alu_OpCode    <= 5'd0;
            alu_funct     <= 2'd0;
            alu_Rs        <= 16'd0;
            alu_Rt        <= 16'd0;
            alu_Pc        <= 16'd0;
            alu_Imm       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt <= chosen;
                        cnt <= 3'(EXEC_CYCLES - 1);
                        if (chosen) begin
                            alu_OpCode <= bus.req1_OpCode;
                            alu_funct  <= bus.req1_funct;
                            alu_Rs     <= bus.req1_Rs;
                            alu_Rt     <= bus.req1_Rt;
                            alu_Pc     <= bus.req1_Pc;
                            alu_Imm    <= bus.req1_Imm;
                        end else begin
                            alu_OpCode <= bus.req0_OpCode;
                            alu_funct  <= bus.req0_funct;
                            alu_Rs     <= bus.req0_Rs;
                            alu_Rt     <= bus.req0_Rt;
                            alu_Pc     <= bus.req0_Pc;
                            alu_Imm    <= bus.req0_Imm;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 3'd0) begin
                        bus.rsp_data       <= alu_res;
                        bus.rsp_valid[gnt] <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[gnt]) begin
                        bus.rsp_valid <= 2'b00;
                        last_grant    <= gnt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule
